mesm6_dmem_arbiter: RTL and testbench

MESM6_DMEM_ARBITER -- requirements
Module: mesm6_dmem_arbiter

---
 rtl/mesm6_dmem_arbiter_if.sv | 45 ++++
 rtl/mesm6_dmem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mesm6_dmem_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mesm6_dmem_arbiter_if.sv
// Bundle of the two requester ports and the shared data-memory port.
// The arbiter takes the slave view; whatever drives requesters and memory takes the master view.
interface mesm6_dmem_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 48
);
  logic [ADDR_W-1:0] m0_addr;
  logic              m0_read;
  logic              m0_write;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_done;

  logic [ADDR_W-1:0] m1_addr;
  logic              m1_read;
  logic              m1_write;
  logic [DATA_W-1:0] m1_wdata;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_done;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;

  modport slave (
    input  m0_addr, m0_read, m0_write, m0_wdata,
    output m0_rdata, m0_done,
    input  m1_addr, m1_read, m1_write, m1_wdata,
    output m1_rdata, m1_done,
    output mem_addr, mem_read, mem_write, mem_wdata,
    input  mem_rdata, mem_done
  );

  modport master (
    output m0_addr, m0_read, m0_write, m0_wdata,
    input  m0_rdata, m0_done,
    output m1_addr, m1_read, m1_write, m1_wdata,
    input  m1_rdata, m1_done,
    input  mem_addr, mem_read, mem_write, mem_wdata,
    output mem_rdata, mem_done
  );
endinterface

// File: rtl/mesm6_dmem_arbiter.sv
// Two-requester round-robin arbiter for the shared data memory, with a BUSY
// timeout that completes the stuck requester with all-ones data and raises a sticky err.
module mesm6_dmem_arbiter #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 48,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  mesm6_dmem_arbiter_if.slave  bus,
  input  logic                 err_clr,
  output logic                 err,
  output logic [1:0]           owner
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The count includes the current cycle, so TIMEOUT BUSY cycles end on count TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [1:0]        owner_q, owner_d;

  logic              req0, req1;
  logic              selReq, selRd, selWr;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;
  logic              doneInt;
  logic [DATA_W-1:0] rdataInt;
  logic              errSet;
  logic              timeoutHit;

  assign req0       = bus.m0_read | bus.m0_write;
  assign req1       = bus.m1_read | bus.m1_write;
  assign timeoutHit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      owner_q <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    errSet        = 1'b0;
    doneInt       = 1'b0;
    rdataInt      = '0;
    selReq        = 1'b0;
    selRd         = 1'b0;
    selWr         = 1'b0;
    selAddr       = '0;
    selWdata      = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;

    if (state_q == BUSY1) begin
      selReq   = req1;
      selRd    = bus.m1_read;
      selWr    = bus.m1_write;
      selAddr  = bus.m1_addr;
      selWdata = bus.m1_wdata;
    end else if (state_q == BUSY0) begin
      selReq   = req0;
      selRd    = bus.m0_read;
      selWr    = bus.m0_write;
      selAddr  = bus.m0_addr;
      selWdata = bus.m0_wdata;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req0 && req1) begin
          state_d = last_q ? BUSY0 : BUSY1;
        end else if (req0) begin
          state_d = BUSY0;
        end else if (req1) begin
          state_d = BUSY1;
        end
      end
      BUSY0, BUSY1: begin
        // A dropped strobe is an abort: no done, and fairness history is left alone.
        if (!selReq) begin
          state_d = IDLE;
        end else begin
          bus.mem_addr  = selAddr;
          bus.mem_wdata = selWdata;
          if (bus.mem_done) begin
            bus.mem_write = selWr;
            bus.mem_read  = selRd & ~selWr;
            doneInt       = 1'b1;
            rdataInt      = bus.mem_rdata;
            state_d       = IDLE;
            last_d        = (state_q == BUSY1);
          end else if (timeoutHit) begin
            doneInt  = 1'b1;
            rdataInt = '1;
            errSet   = 1'b1;
            state_d  = IDLE;
            last_d   = (state_q == BUSY1);
          end else begin
            bus.mem_write = selWr;
            bus.mem_read  = selRd & ~selWr;
            cnt_d         = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    bus.m0_done  = doneInt && (state_q == BUSY0);
    bus.m1_done  = doneInt && (state_q == BUSY1);
    bus.m0_rdata = (state_q == BUSY0) ? rdataInt : '0;
    bus.m1_rdata = (state_q == BUSY1) ? rdataInt : '0;
  end

  always_comb begin
    err_d = err_q;
    if (errSet) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
    case (state_d)
      BUSY0:   owner_d = 2'b01;
      BUSY1:   owner_d = 2'b10;
      default: owner_d = 2'b00;
    endcase
  end

  assign err   = err_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_mesm6_dmem_arbiter.sv
// Directed bench for mesm6_dmem_arbiter: expected done responses go into a
// scoreboard queue and a negedge monitor pops them whenever a requester sees done.
module tb_mesm6_dmem_arbiter;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 48;

  logic       clk;
  logic       reset;
  logic       err_clr;
  logic       err;
  logic [1:0] owner;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int                who;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  exp_t expQ[$];

  mesm6_dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mesm6_dmem_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .err_clr(err_clr),
    .err    (err),
    .owner  (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (!reset && (bus.m0_done || bus.m1_done)) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", {62'b0, bus.m1_done, bus.m0_done}, 64'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("done_owner", {62'b0, bus.m1_done, bus.m0_done}, (e.who == 0) ? 64'd1 : 64'd2);
        checkOutput("done_rdata", (e.who == 0) ? bus.m0_rdata : bus.m1_rdata, e.rdata);
        checkOutput("other_rdata", (e.who == 0) ? bus.m1_rdata : bus.m0_rdata, 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int who, input logic rd, input logic wr,
                               input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    if (who == 0) begin
      bus.m0_read  = rd;
      bus.m0_write = wr;
      bus.m0_addr  = addr;
      bus.m0_wdata = wdata;
    end else begin
      bus.m1_read  = rd;
      bus.m1_write = wr;
      bus.m1_addr  = addr;
      bus.m1_wdata = wdata;
    end
  endtask

  // Bounded wait for a grant; lands in the first BUSY cycle.
  task automatic waitGrant(input int who, input logic [ADDR_W-1:0] expAddr);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (owner != 2'b00) break;
    end
    checkOutput("grant_owner", owner, (who == 0) ? 64'd1 : 64'd2);
    checkOutput("grant_addr", bus.mem_addr, expAddr);
  endtask

  task automatic finishTxn(input int who, input logic [DATA_W-1:0] data);
    exp_t e;
    bus.mem_done  = 1'b1;
    bus.mem_rdata = data;
    e.who   = who;
    e.rdata = data;
    expQ.push_back(e);
    tick();
    bus.mem_done  = 1'b0;
    bus.mem_rdata = '0;
    applyStimulus(who, 1'b0, 1'b0, '0, '0);
    checkOutput("idle_gap_owner", owner, 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    reset         = 1'b1;
    err_clr       = 1'b0;
    bus.mem_done  = 1'b0;
    bus.mem_rdata = '0;
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1, 1'b0, 1'b0, '0, '0);
    repeat (2) tick();
    checkOutput("rst_owner", owner, 64'd0);
    checkOutput("rst_err", err, 64'd0);
    checkOutput("rst_mem_read", bus.mem_read, 64'd0);
    checkOutput("rst_mem_write", bus.mem_write, 64'd0);
    checkOutput("rst_m0_done", bus.m0_done, 64'd0);
    reset = 1'b0;
    tick();

    // Simultaneous requests: m0 first after reset, then strict alternation.
    for (int r = 0; r < 4; r++) begin
      applyStimulus(0, 1'b1, 1'b0, 15'h0100 + 15'(r), '0);
      applyStimulus(1, 1'b1, 1'b0, 15'h0200 + 15'(r), '0);
      waitGrant(0, 15'h0100 + 15'(r));
      finishTxn(0, 48'h0000_0000_1000 + 48'(r));
      waitGrant(1, 15'h0200 + 15'(r));
      finishTxn(1, 48'h0000_0000_2000 + 48'(r));
    end

    // Plain m0 read answered two cycles into BUSY.
    applyStimulus(0, 1'b1, 1'b0, 15'h0010, '0);
    waitGrant(0, 15'h0010);
    checkOutput("rd_mem_read", bus.mem_read, 64'd1);
    tick();
    tick();
    finishTxn(0, 48'hABCD_EF01_2345);

    // Read+write together is a write.
    applyStimulus(1, 1'b1, 1'b1, 15'h7FFF, 48'h1);
    waitGrant(1, 15'h7FFF);
    checkOutput("rw_mem_write", bus.mem_write, 64'd1);
    checkOutput("rw_mem_read", bus.mem_read, 64'd0);
    checkOutput("rw_mem_wdata", bus.mem_wdata, 64'd1);
    finishTxn(1, 48'h0);

    // Timeout after 8 BUSY cycles without mem_done.
    applyStimulus(0, 1'b1, 1'b0, 15'h0020, '0);
    waitGrant(0, 15'h0020);
    for (int c = 2; c <= 8; c++) begin
      tick();
      if (c == 8) begin
        e.who   = 0;
        e.rdata = '1;
        expQ.push_back(e);
        checkOutput("to_mem_read", bus.mem_read, 64'd0);
        checkOutput("to_err_before", err, 64'd0);
      end
    end
    tick();
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    checkOutput("to_err_set", err, 64'd1);
    checkOutput("to_owner", owner, 64'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("to_err_clr", err, 64'd0);

    // mem_done in the timeout cycle completes normally.
    applyStimulus(0, 1'b1, 1'b0, 15'h0030, '0);
    waitGrant(0, 15'h0030);
    for (int c = 2; c < 8; c++) tick();
    tick();
    finishTxn(0, 48'h1234_5678_9ABC);
    checkOutput("to_edge_err", err, 64'd0);

    // Abort: strobe drops mid-BUSY.
    applyStimulus(1, 1'b1, 1'b0, 15'h0055, '0);
    waitGrant(1, 15'h0055);
    tick();
    applyStimulus(1, 1'b0, 1'b0, '0, '0);
    #1;
    checkOutput("abort_mem_read", bus.mem_read, 64'd0);
    tick();
    checkOutput("abort_owner", owner, 64'd0);

    // Reset in BUSY1, then m0 wins the first tie.
    applyStimulus(1, 1'b1, 1'b0, 15'h0066, '0);
    waitGrant(1, 15'h0066);
    reset = 1'b1;
    tick();
    checkOutput("rstbusy_owner", owner, 64'd0);
    checkOutput("rstbusy_mem_read", bus.mem_read, 64'd0);
    checkOutput("rstbusy_mem_write", bus.mem_write, 64'd0);
    applyStimulus(0, 1'b1, 1'b0, 15'h0077, '0);
    reset = 1'b0;
    waitGrant(0, 15'h0077);
    finishTxn(0, 48'h0000_0000_7777);
    waitGrant(1, 15'h0066);
    finishTxn(1, 48'h0000_0000_6666);

    tick();
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
